timer_sequencer: RTL

TIMER_SEQUENCER -- requirements
Module: timer_sequencer

---
 rtl/timer_sequencer_pkg.sv | 70 +++++++
 rtl/timer_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// timer_sequencer_pkg
// Shared definitions for the interval-timer sequencer: FSM state encoding,
// timer register map, control/status bit positions, canned control words
// and a small bus-record type with constructor helpers.
// ---------------------------------------------------------------------------
package timer_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_PL    = 4'd1,
    S_WR_PH    = 4'd2,
    S_WR_CTL   = 4'd3,
    S_WAIT_IRQ = 4'd4,
    S_RD_STAT  = 4'd5,
    S_RD_WAIT  = 4'd6,
    S_CLR_TO   = 4'd7,
    S_STOP     = 4'd8,
    S_DONE     = 4'd9
  } state_e;

  // Interval timer register map (16-bit word addresses)
  localparam logic [2:0] TMR_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERIODH = 3'd3;

  // Status / control bit positions
  localparam int unsigned STAT_TO_BIT    = 0;
  localparam int unsigned CTRL_ITO_BIT   = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_START_BIT = 2;
  localparam int unsigned CTRL_STOP_BIT  = 3;

  // Control words: run continuously with interrupt, or stop with everything off
  localparam logic [15:0] CTRL_RUN  = (16'h0001 << CTRL_ITO_BIT)
                                    | (16'h0001 << CTRL_CONT_BIT)
                                    | (16'h0001 << CTRL_START_BIT);
  localparam logic [15:0] CTRL_STOP = (16'h0001 << CTRL_STOP_BIT);

  // One cycle worth of master-side bus signals
  typedef struct packed {
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
  } tmr_bus_t;

  localparam tmr_bus_t TMR_BUS_IDLE = '{address: 3'd0, chipselect: 1'b0,
                                        write_n: 1'b1, writedata: 16'h0000};

  function automatic tmr_bus_t tmr_write(input logic [2:0] addr, input logic [15:0] data);
    tmr_bus_t b;
    b.address    = addr;
    b.chipselect = 1'b1;
    b.write_n    = 1'b0;
    b.writedata  = data;
    return b;
  endfunction

  function automatic tmr_bus_t tmr_read(input logic [2:0] addr);
    tmr_bus_t b;
    b.address    = addr;
    b.chipselect = 1'b1;
    b.write_n    = 1'b1;
    b.writedata  = 16'h0000;
    return b;
  endfunction

endpackage

// File: rtl/timer_sequencer.sv
// ---------------------------------------------------------------------------
// timer_sequencer
// Programs an Avalon-MM interval timer with a 32-bit period, starts it in
// continuous mode with interrupt, services each timeout (status read,
// spurious-interrupt filtering, TO clear), counts ticks and stops the timer
// after cmd_count timeouts (0 = run until abort).
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_period (32b), cmd_count
//   abort                 single-cycle stop request
//   tmr_*                 Avalon-MM master to the timer (no waitrequest,
//                         registered readdata with 1-cycle latency)
//   busy, tick_pulse,     status: not idle, one pulse per serviced timeout,
//   tick_count, done      serviced-timeout counter, end-of-sequence pulse
//
// All outputs are registered: they are decoded from the next state and
// loaded together with the state register, so each output reflects the
// state the FSM is in during that cycle.
// ---------------------------------------------------------------------------
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [31:0]        cmd_period,
  input  logic [COUNT_W-1:0] cmd_count,
  input  logic               abort,
  output logic [2:0]         tmr_address,
  output logic               tmr_chipselect,
  output logic               tmr_write_n,
  output logic [15:0]        tmr_writedata,
  input  logic [15:0]        tmr_readdata,
  input  logic               tmr_irq,
  output logic               busy,
  output logic               tick_pulse,
  output logic [COUNT_W-1:0] tick_count,
  output logic               done
);

  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_e             r_state;
  state_e             w_next_state;
  logic [31:0]        r_period;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_tick_count;
  logic               r_abort_pend;
  tmr_bus_t           r_bus;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_tick_pulse;
  logic               r_done;

  logic               w_accept;
  logic               w_abort;
  logic               w_timeout;
  logic [COUNT_W-1:0] w_tick_inc;
  logic [31:0]        w_period_nxt;
  tmr_bus_t           w_bus_nxt;
  logic               w_unused_rdata;

  assign w_accept   = (r_state == S_IDLE) && cmd_valid;
  // A pending abort and a fresh one are treated alike
  assign w_abort    = abort || r_abort_pend;
  assign w_timeout  = tmr_readdata[STAT_TO_BIT];
  assign w_tick_inc = r_tick_count + CNT_ONE;
  // Only the TO flag of the status word matters here
  assign w_unused_rdata = ^tmr_readdata[15:1];

  // Period that will be in force next cycle; zero is promoted to one
  always_comb begin
    w_period_nxt = r_period;
    if (w_accept) begin
      w_period_nxt = (cmd_period == 32'd0) ? 32'd1 : cmd_period;
    end else begin
      w_period_nxt = r_period;
    end
  end

  // Next-state logic; abort wins over every transition out of an active state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_WR_PL;
        else          w_next_state = S_IDLE;
      end
      S_WR_PL: begin
        if (w_abort) w_next_state = S_STOP;
        else         w_next_state = S_WR_PH;
      end
      S_WR_PH: begin
        if (w_abort) w_next_state = S_STOP;
        else         w_next_state = S_WR_CTL;
      end
      S_WR_CTL: begin
        if (w_abort) w_next_state = S_STOP;
        else         w_next_state = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (w_abort)      w_next_state = S_STOP;
        else if (tmr_irq) w_next_state = S_RD_STAT;
        else              w_next_state = S_WAIT_IRQ;
      end
      S_RD_STAT: begin
        if (w_abort) w_next_state = S_STOP;
        else         w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // TO clear means the interrupt was spurious: keep waiting
        if (w_abort)        w_next_state = S_STOP;
        else if (w_timeout) w_next_state = S_CLR_TO;
        else                w_next_state = S_WAIT_IRQ;
      end
      S_CLR_TO: begin
        if (w_abort)                                          w_next_state = S_STOP;
        else if ((r_count != CNT_ZERO) && (w_tick_inc == r_count)) w_next_state = S_STOP;
        else                                                  w_next_state = S_WAIT_IRQ;
      end
      S_STOP:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bus cycle to present while in the next state
  always_comb begin
    w_bus_nxt = TMR_BUS_IDLE;
    case (w_next_state)
      S_WR_PL:   w_bus_nxt = tmr_write(TMR_ADDR_PERIODL, w_period_nxt[15:0]);
      S_WR_PH:   w_bus_nxt = tmr_write(TMR_ADDR_PERIODH, w_period_nxt[31:16]);
      S_WR_CTL:  w_bus_nxt = tmr_write(TMR_ADDR_CONTROL, CTRL_RUN);
      S_RD_STAT: w_bus_nxt = tmr_read(TMR_ADDR_STATUS);
      S_CLR_TO:  w_bus_nxt = tmr_write(TMR_ADDR_STATUS, 16'h0000);
      S_STOP:    w_bus_nxt = tmr_write(TMR_ADDR_CONTROL, CTRL_STOP);
      default:   w_bus_nxt = TMR_BUS_IDLE;
    endcase
  end

  // State register and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_bus        <= TMR_BUS_IDLE;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_tick_pulse <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_bus        <= w_bus_nxt;
      r_cmd_ready  <= (w_next_state == S_IDLE);
      r_busy       <= (w_next_state != S_IDLE);
      r_tick_pulse <= (w_next_state == S_CLR_TO);
      r_done       <= (w_next_state == S_DONE);
    end
  end

  // Command latch and tick counter; a tick counts even when CLR_TO is aborted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period     <= 32'd0;
      r_count      <= CNT_ZERO;
      r_tick_count <= CNT_ZERO;
    end else if (w_accept) begin
      r_period     <= w_period_nxt;
      r_count      <= cmd_count;
      r_tick_count <= CNT_ZERO;
    end else if (r_state == S_CLR_TO) begin
      r_tick_count <= w_tick_inc;
    end
  end

  // Abort request pending flag; ignored and cleared outside the active states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_abort_pend <= 1'b0;
    end else if ((r_state == S_IDLE) || (r_state == S_STOP) || (r_state == S_DONE)) begin
      r_abort_pend <= 1'b0;
    end else if (abort) begin
      r_abort_pend <= 1'b1;
    end
  end

  assign tmr_address    = r_bus.address;
  assign tmr_chipselect = r_bus.chipselect;
  assign tmr_write_n    = r_bus.write_n;
  assign tmr_writedata  = r_bus.writedata;
  assign cmd_ready      = r_cmd_ready;
  assign busy           = r_busy;
  assign tick_pulse     = r_tick_pulse;
  assign tick_count     = r_tick_count;
  assign done           = r_done;

endmodule
